// File: rtl/ball_engine_2d.sv
// ball_engine_2d: moves a square ball across a playfield at a rate set by a
// tick divider. The ball reflects off the left, top and bottom walls and off
// paddle hits. Reaching the right edge without a hit is a miss, which holds
// the ball in MISS for a fixed time and then returns to IDLE for a new serve.
module ball_engine_2d #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BALL_SIZE      = 20,
  parameter int POS_W          = 10,
  parameter int CNT_W          = 20,
  parameter int SLOW_DIV       = 270000,
  parameter int FAST_DIV       = 125000,
  parameter int SPEED_THRESH   = 20,
  parameter int LEVEL_STEP     = 10000,
  parameter int MIN_DIV        = 40000,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 7,
  parameter int MISS_HOLD      = 25000000,
  parameter int START_X        = 100,
  parameter int START_Y        = 80
) (
  input  logic             clk_25MHZ,
  input  logic             reset_n,
  input  logic             upscale,
  input  logic             collision_detected,
  input  logic [9:0]       estimated_speed,
  input  logic             serve,
  input  logic             pause,
  output logic [POS_W-1:0] ball_x_out,
  output logic [POS_W-1:0] ball_y_out,
  output logic             dir_x,
  output logic             dir_y,
  output logic             miss_pulse,
  output logic [7:0]       hit_count,
  output logic [2:0]       level,
  output logic [1:0]       state_out
);

  // Divisor arithmetic is carried 4 bits wider than the counter so the
  // level subtraction and floor compare never wrap.
  localparam int DIV_W = CNT_W + 4;
  // Field bounds need headroom above the position width.
  localparam int FW_W  = POS_W + 2;
  localparam int MC_W  = (MISS_HOLD > 1) ? $clog2(MISS_HOLD + 1) : 1;
  localparam int HL_W  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [POS_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic             r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [MC_W-1:0]  r_miss_cnt, w_miss_cnt_nxt;
  logic [HL_W-1:0]  r_hsub, w_hsub_nxt;
  logic [7:0]       r_hit, w_hit_nxt;
  logic [2:0]       r_level, w_level_nxt;
  logic             r_miss_pulse, w_miss_pulse_nxt;
  logic             r_coll_q;

  logic [FW_W-1:0]  w_fw, w_fh, w_x_lim, w_y_lim;
  logic             w_x_edge, w_y_edge;
  logic [DIV_W-1:0] w_base, w_dec, w_div;
  logic             w_tick, w_coll_rise;

  // Field bounds and the edge thresholds for the ball's top-left corner.
  always_comb begin
    w_fw     = upscale ? FW_W'(H_RES) : FW_W'(H_RES / 2);
    w_fh     = upscale ? FW_W'(V_RES) : FW_W'(V_RES / 2);
    w_x_lim  = w_fw - FW_W'(BALL_SIZE);
    w_y_lim  = w_fh - FW_W'(BALL_SIZE);
    w_x_edge = FW_W'(r_x) >= w_x_lim;
    w_y_edge = FW_W'(r_y) >= w_y_lim;
  end

  // Move-rate divisor: speed selects the base, each level shaves a step off,
  // and the result is floored so high levels cannot stall or race the ball.
  always_comb begin
    w_base = (estimated_speed > 10'(SPEED_THRESH)) ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
    w_dec  = DIV_W'(r_level) * DIV_W'(LEVEL_STEP);
    w_div  = (w_base >= w_dec + DIV_W'(MIN_DIV)) ? (w_base - w_dec) : DIV_W'(MIN_DIV);
    w_tick = DIV_W'(r_cnt) >= w_div;
  end

  // A held collision level counts once; only its rising edge is a hit.
  assign w_coll_rise = collision_detected & ~r_coll_q;

  // State register.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and datapath update; first matching RUN rule wins.
  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_dir_x_nxt      = r_dir_x;
    w_dir_y_nxt      = r_dir_y;
    w_cnt_nxt        = r_cnt;
    w_miss_cnt_nxt   = r_miss_cnt;
    w_hsub_nxt       = r_hsub;
    w_hit_nxt        = r_hit;
    w_level_nxt      = r_level;
    w_miss_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_x_nxt   = POS_W'(START_X);
        w_y_nxt   = POS_W'(START_Y);
        w_cnt_nxt = '0;
        if (serve) begin
          w_state_nxt = S_RUN;
          w_dir_x_nxt = 1'b0;
          w_dir_y_nxt = 1'b1;
          w_hit_nxt   = '0;
          w_level_nxt = '0;
          w_hsub_nxt  = '0;
        end
      end
      S_RUN: begin
        if (pause) begin
          // freeze everything; the collision edge register still tracks
        end else if (w_coll_rise && r_dir_x) begin
          w_dir_x_nxt = 1'b0;
          w_cnt_nxt   = '0;
          if (r_hit != 8'hFF) w_hit_nxt = r_hit + 8'd1;
          if (r_hsub == HL_W'(HITS_PER_LEVEL - 1)) begin
            w_hsub_nxt = '0;
            if (r_level != 3'(MAX_LEVEL)) w_level_nxt = r_level + 3'd1;
          end else begin
            w_hsub_nxt = r_hsub + HL_W'(1);
          end
        end else if (r_dir_x && w_x_edge) begin
          w_state_nxt      = S_MISS;
          w_miss_pulse_nxt = 1'b1;
          w_miss_cnt_nxt   = '0;
        end else if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_dir_x && (r_x == '0)) begin
            w_dir_x_nxt = 1'b1;
            w_x_nxt     = POS_W'(1);
          end else begin
            w_x_nxt = r_dir_x ? (r_x + POS_W'(1)) : (r_x - POS_W'(1));
          end
          if (r_dir_y && w_y_edge) begin
            w_dir_y_nxt = 1'b0;
            w_y_nxt     = r_y - POS_W'(1);
          end else if (!r_dir_y && (r_y == '0)) begin
            w_dir_y_nxt = 1'b1;
            w_y_nxt     = POS_W'(1);
          end else begin
            w_y_nxt = r_dir_y ? (r_y + POS_W'(1)) : (r_y - POS_W'(1));
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_MISS: begin
        if (r_miss_cnt == MC_W'(MISS_HOLD - 1)) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = POS_W'(START_X);
          w_y_nxt     = POS_W'(START_Y);
          w_cnt_nxt   = '0;
        end else begin
          w_miss_cnt_nxt = r_miss_cnt + MC_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= POS_W'(START_X);
      r_y          <= POS_W'(START_Y);
      r_dir_x      <= 1'b0;
      r_dir_y      <= 1'b1;
      r_cnt        <= '0;
      r_miss_cnt   <= '0;
      r_hsub       <= '0;
      r_hit        <= '0;
      r_level      <= '0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_dir_x      <= w_dir_x_nxt;
      r_dir_y      <= w_dir_y_nxt;
      r_cnt        <= w_cnt_nxt;
      r_miss_cnt   <= w_miss_cnt_nxt;
      r_hsub       <= w_hsub_nxt;
      r_hit        <= w_hit_nxt;
      r_level      <= w_level_nxt;
      r_miss_pulse <= w_miss_pulse_nxt;
    end
  end

  // Collision edge register, updated every cycle in every state.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) r_coll_q <= 1'b0;
    else          r_coll_q <= collision_detected;
  end

  assign ball_x_out = r_x;
  assign ball_y_out = r_y;
  assign dir_x      = r_dir_x;
  assign dir_y      = r_dir_y;
  assign miss_pulse = r_miss_pulse;
  assign hit_count  = r_hit;
  assign level      = r_level;
  assign state_out  = r_state;

endmodule

// File: tb/tb_ball_engine_2d.sv
// Bench for ball_engine_2d with small field/divisor parameters. Expected
// output values are queued against the cycle they must appear in; a monitor
// on the falling edge pops due entries and compares them with the DUT.
module tb_ball_engine_2d;

  localparam int F_X = 0, F_Y = 1, F_DX = 2, F_DY = 3, F_ST = 4, F_HIT = 5, F_LVL = 6, F_MP = 7;

  typedef struct packed {
    int cyc;
    int fld;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upscale = 1'b1;
  logic       coll = 1'b0;
  logic [9:0] speed = 10'd5;
  logic       serve = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] bx, by;
  logic       dx, dy, mp;
  logic [7:0] hits;
  logic [2:0] lvl;
  logic [1:0] st;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   drain = 1'b0;
  exp_t sb[$];
  exp_t me;
  int   act;

  ball_engine_2d #(
    .H_RES(64), .V_RES(48), .BALL_SIZE(4), .POS_W(10), .CNT_W(20),
    .SLOW_DIV(3), .FAST_DIV(1), .SPEED_THRESH(20), .LEVEL_STEP(1), .MIN_DIV(0),
    .HITS_PER_LEVEL(2), .MAX_LEVEL(7), .MISS_HOLD(5), .START_X(10), .START_Y(8)
  ) dut (
    .clk_25MHZ(clk), .reset_n(rst_n), .upscale(upscale),
    .collision_detected(coll), .estimated_speed(speed),
    .serve(serve), .pause(pause),
    .ball_x_out(bx), .ball_y_out(by), .dir_x(dx), .dir_y(dy),
    .miss_pulse(mp), .hit_count(hits), .level(lvl), .state_out(st)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fval(input int f);
    case (f)
      F_X:     return int'(bx);
      F_Y:     return int'(by);
      F_DX:    return int'(dx);
      F_DY:    return int'(dy);
      F_ST:    return int'(st);
      F_HIT:   return int'(hits);
      F_LVL:   return int'(lvl);
      default: return int'(mp);
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_X:     return "ball_x";
      F_Y:     return "ball_y";
      F_DX:    return "dir_x";
      F_DY:    return "dir_y";
      F_ST:    return "state";
      F_HIT:   return "hit_count";
      F_LVL:   return "level";
      default: return "miss_pulse";
    endcase
  endfunction

  // Queue kept sorted by cycle so phases may push in any order.
  task automatic ex(input int c, input int f, input int v);
    exp_t e;
    int   i;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every entry that has come due; leftovers at the end fail.
  always @(negedge clk) begin
    while (sb.size() > 0 && (drain || sb[0].cyc <= cyc)) begin
      me = sb.pop_front();
      n_vec++;
      if (me.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: not checked at cycle %0d, wanted %0d",
                 fname(me.fld), cyc, me.cyc, me.val);
      end else begin
        act = fval(me.fld);
        if (act != me.val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %0d, want %0d", fname(me.fld), cyc, act, me.val);
        end
      end
    end
  end

  initial begin
    int c, b, g;
    // reset state, held in reset then released into IDLE
    goto(2);
    ex(2, F_X, 10); ex(2, F_Y, 8); ex(2, F_DX, 0); ex(2, F_DY, 1);
    ex(2, F_ST, 0); ex(2, F_HIT, 0); ex(2, F_LVL, 0); ex(2, F_MP, 0);
    rst_n = 1'b1;
    ex(3, F_ST, 0); ex(3, F_X, 10);

    // serve, slow rate, x wall bounce, two hits, y bounce, right-edge miss
    c = 4;
    goto(c);
    ex(c, F_ST, 0);
    ex(c+1, F_ST, 1); ex(c+1, F_HIT, 0);
    ex(c+4, F_X, 10); ex(c+4, F_Y, 8);
    ex(c+5, F_X, 9);  ex(c+5, F_Y, 9);
    ex(c+8, F_X, 9);
    ex(c+9, F_X, 8);  ex(c+9, F_Y, 10);
    ex(c+41, F_X, 0); ex(c+41, F_DX, 0); ex(c+41, F_Y, 18);
    ex(c+45, F_X, 1); ex(c+45, F_DX, 1); ex(c+45, F_Y, 19);
    ex(c+47, F_X, 1); ex(c+47, F_DX, 0); ex(c+47, F_HIT, 1); ex(c+47, F_LVL, 0);
    ex(c+51, F_X, 0); ex(c+51, F_Y, 20);
    ex(c+55, F_X, 1); ex(c+55, F_DX, 1);
    ex(c+59, F_X, 2); ex(c+59, F_Y, 22);
    ex(c+61, F_X, 2); ex(c+61, F_DX, 0); ex(c+61, F_HIT, 2); ex(c+61, F_LVL, 1);
    ex(c+63, F_X, 2);
    ex(c+64, F_X, 1); ex(c+64, F_Y, 23);
    ex(c+70, F_X, 1); ex(c+70, F_DX, 1); ex(c+70, F_Y, 25); ex(c+70, F_HIT, 2);
    ex(c+127, F_Y, 44); ex(c+127, F_X, 20); ex(c+127, F_DY, 1);
    ex(c+130, F_Y, 43); ex(c+130, F_DY, 0); ex(c+130, F_X, 21);
    ex(c+247, F_X, 60); ex(c+247, F_ST, 1); ex(c+247, F_MP, 0);
    ex(c+248, F_ST, 2); ex(c+248, F_MP, 1); ex(c+248, F_X, 60);
    ex(c+249, F_ST, 2); ex(c+249, F_MP, 0);
    ex(c+252, F_ST, 2);
    ex(c+253, F_ST, 0); ex(c+253, F_X, 10); ex(c+253, F_Y, 8);
    ex(c+253, F_HIT, 2); ex(c+253, F_LVL, 1);
    serve = 1'b1;
    goto(c+1);  serve = 1'b0;
    goto(c+46); coll = 1'b1;
    goto(c+56); coll = 1'b0;
    goto(c+60); coll = 1'b1;
    goto(c+70); coll = 1'b0;
    goto(c+253);

    // reserve, pause keeps phase, upscale drop forces an early miss
    b = c + 255;
    goto(b);
    ex(b+1, F_ST, 1); ex(b+1, F_HIT, 0); ex(b+1, F_LVL, 0);
    ex(b+5, F_X, 9);  ex(b+5, F_Y, 9);
    ex(b+6, F_X, 9);
    ex(b+26, F_X, 9); ex(b+26, F_Y, 9);
    ex(b+28, F_X, 9);
    ex(b+29, F_X, 8); ex(b+29, F_Y, 10);
    ex(b+61, F_X, 0); ex(b+61, F_Y, 18);
    ex(b+65, F_X, 1); ex(b+65, F_DX, 1);
    ex(b+221, F_X, 40); ex(b+221, F_Y, 30); ex(b+221, F_ST, 1);
    ex(b+222, F_ST, 2); ex(b+222, F_MP, 1); ex(b+222, F_X, 40);
    ex(b+227, F_ST, 0); ex(b+227, F_X, 10); ex(b+227, F_Y, 8);
    serve = 1'b1;
    goto(b+1);   serve = 1'b0;
    goto(b+6);   pause = 1'b1;
    goto(b+26);  pause = 1'b0;
    goto(b+221); upscale = 1'b0;
    goto(b+222); upscale = 1'b1;
    goto(b+227);

    // fast rate, then asynchronous reset mid-cycle
    g = b + 229;
    speed = 10'd30;
    goto(g);
    ex(g+1, F_ST, 1);
    ex(g+2, F_X, 10);
    ex(g+3, F_X, 9); ex(g+3, F_Y, 9);
    ex(g+4, F_X, 9);
    ex(g+5, F_X, 8); ex(g+5, F_Y, 10);
    ex(g+6, F_X, 10); ex(g+6, F_Y, 8); ex(g+6, F_ST, 0);
    ex(g+6, F_DX, 0); ex(g+6, F_DY, 1); ex(g+6, F_HIT, 0); ex(g+6, F_LVL, 0);
    serve = 1'b1;
    goto(g+1); serve = 1'b0;
    goto(g+6); rst_n = 1'b0;
    goto(g+8); rst_n = 1'b1; speed = 10'd5;
    goto(g+10);
    drain = 1'b1;
    goto(g+12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_engine_2d.md
Name: ball_engine_2d

Overview:
Parametrised successor to the 1-D ball mover in the video game path. Moves a square ball in X and Y at a rate set by a clock-divider tick. The rate depends on the camera speed estimate and on a hit-driven level. Reflects off the left, top and bottom walls and off paddle collisions. Reaching the right edge without a hit is a miss, which triggers a serve cycle. Outputs feed the overlay renderer and the collision detector.

Parameters:
H_RES, 640, full-resolution field width in pixels (halved when upscale=0)
V_RES, 480, full-resolution field height in pixels (halved when upscale=0)
BALL_SIZE, 20, ball edge length in pixels
POS_W, 10, width of the position outputs
CNT_W, 20, width of the tick counter and divisors
SLOW_DIV, 270000, base divisor when estimated_speed <= SPEED_THRESH
FAST_DIV, 125000, base divisor when estimated_speed > SPEED_THRESH
SPEED_THRESH, 20, estimated_speed threshold
LEVEL_STEP, 10000, divisor reduction per level
MIN_DIV, 40000, divisor floor
HITS_PER_LEVEL, 4, hits needed to advance one level
MAX_LEVEL, 7, level saturation value
MISS_HOLD, 25000000, number of cycles spent in MISS
START_X, 100, serve X position
START_Y, 80, serve Y position

Ports:
clk_25MHZ  input  1  pixel clock; the only clock
reset_n  input  1  asynchronous, active-low reset
upscale  input  1  1: field is H_RES x V_RES; 0: field is H_RES/2 x V_RES/2
collision_detected  input  1  paddle overlap level from the collision detector
estimated_speed  input  10  motion-speed estimate from the camera path
serve  input  1  level input; starts play from IDLE
pause  input  1  freezes all RUN activity while high
ball_x_out  output  POS_W  ball X position (top-left corner)
ball_y_out  output  POS_W  ball Y position (top-left corner)
dir_x  output  1  1 = moving right
dir_y  output  1  1 = moving down
miss_pulse  output  1  one-cycle pulse on entry to MISS
hit_count  output  8  hits since the last serve; saturates at 255
level  output  3  current speed level
state_out  output  2  IDLE=0, RUN=1, MISS=2

Behaviour:
- Reset (asynchronous, active-low) drives:
  - state=IDLE
  - ball_x_out=START_X, ball_y_out=START_Y
  - dir_x=0, dir_y=1
  - counter=0, hit_count=0, level=0, miss_pulse=0
  - collision edge register cleared to 0
- Field bounds are combinational and evaluated every cycle:
  - fw = upscale ? H_RES : H_RES/2
  - fh = upscale ? V_RES : V_RES/2
- Divisor:
  - div = base − level×LEVEL_STEP, floored at MIN_DIV
  - base = (estimated_speed > SPEED_THRESH) ? FAST_DIV : SLOW_DIV
  - Computed at CNT_W+4 bits, no wrap.
- tick = (counter >= div). On a tick the counter clears; otherwise it increments. One move occurs every div+1 cycles.
- coll_rise = collision_detected & ~collision_detected_q, where collision_detected_q is a registered copy updated every cycle.
- IDLE:
  - Ball held at START, counter=0.
  - If serve=1, next cycle: state=RUN, dir_x=0, dir_y=1, hit_count=0, level=0.
- RUN: apply the first matching rule each cycle.
  1. pause=1: all registers hold. collision_detected_q still updates, so a rise that occurs during pause is lost.
  2. coll_rise & dir_x=1:
     - dir_x←0, counter←0
     - hit_count+1 (saturating at 255)
     - Every HITS_PER_LEVEL-th hit, level+1 (saturating at MAX_LEVEL)
     - Position holds.
  3. dir_x=1 & ball_x_out >= fw−BALL_SIZE: state←MISS, miss_pulse=1 next cycle.
  4. tick, X axis:
     - Moving left with x=0: dir_x←1, x←1.
     - Otherwise: x±1.
  5. tick, Y axis (same cycle as rule 4):
     - dir_y=1 & y >= fh−BALL_SIZE: dir_y←0, y←y−1.
     - dir_y=0 & y=0: dir_y←1, y←1.
     - Otherwise: y±1.
  6. No tick: counter+1.
- coll_rise while dir_x=0 is ignored; the ball is already leaving.
- upscale falling mid-RUN:
  - X beyond the new fw while moving right → MISS on the next cycle.
  - Y beyond the new fh while moving down → reflects on the next tick.
- MISS:
  - Position frozen.
  - Holds for MISS_HOLD cycles, then IDLE with the ball at START.
  - hit_count and level hold until the next serve.
- Mid-operation reset returns to the IDLE reset values immediately; no partial-state retention.
- All outputs are registered.

Test Plan:
- Sim parameters: H_RES=64, V_RES=48, BALL_SIZE=4, SLOW_DIV=3, FAST_DIV=1, LEVEL_STEP=1, MIN_DIV=0, HITS_PER_LEVEL=2, MISS_HOLD=5, START_X=10, START_Y=8, upscale=1.
- Serve, estimated_speed=5 → ball moves once every 4 cycles: (10,8)→(9,9)→(8,10); state_out=1 one cycle after serve.
- Run to x=0 → next tick x=1, dir_x=1. Run to y=44 moving down → dir_y=0, y=43.
- Pulse collision_detected 2 times while moving right, holding high 10 cycles each → hit_count=2 (not 20), level=1, divisor=2 (tick every 3 cycles), dir_x=0 immediately after each rise.
- No collision, reach x=60 → miss_pulse high exactly 1 cycle, state_out=2 for 5 cycles, then IDLE with ball at (10,8).
- pause=1 for 20 cycles mid-run → position and counter unchanged; release → motion resumes with the same phase. upscale 1→0 at x=40 moving right → MISS next cycle.
- Assert reset_n low asynchronously mid-RUN → outputs at reset values before the next clk_25MHZ edge; estimated_speed=30 after serve → tick every 2 cycles.
